// File: rtl/core_pkg.sv
// Shared core constants: PC step, reset PC default, pc_gen state encoding and
// the JALR target bit-0 clearing helper.
package core_pkg;

    localparam logic [31:0] CORE_PC_STEP  = 32'd4;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

    typedef logic [1:0] pc_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;

    function automatic logic [31:0] clear_jalr_lsb(input logic [31:0] raw, input logic is_jalr);
        return raw & (is_jalr ? ~32'h1 : ~32'h0);
    endfunction

endpackage

// File: rtl/pc_target_align.sv
// Redirect target conditioning: clears the JALR LSB and flags misalignment.
// With MISALIGN_TRAP_EN undefined, the low two bits are forced to zero and no flag exists.
module pc_target_align
    import core_pkg::*;
(
    input  logic [31:0] redir_target,
    input  logic        redir_is_jalr,
    output logic [31:0] target
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    logic [31:0] cleared;

    assign cleared = clear_jalr_lsb(redir_target, redir_is_jalr);

`ifdef MISALIGN_TRAP_EN
    assign target     = cleared;
    assign misaligned = |cleared[1:0];
`else
    assign target     = cleared & ~32'h3;
`endif

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator / fetch-address issuer with redirect flush.
// Optional misaligned-target trap state enabled by MISALIGN_TRAP_EN.
//
//  state    | meaning
//  IDLE     | just out of reset, no fetch request yet
//  FETCH    | issuing sequential fetch addresses
//  TRAP     | misaligned redirect seen, fetch stalled until aligned redirect
module pc_gen
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CORE_RESET_PC,
    parameter logic [31:0] PC_STEP  = CORE_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RedirValid,
    input  logic [31:0] RedirTarget,
    input  logic        RedirIsJalr,
    input  logic        FetchReady,
    output logic        FetchValid,
    output logic [31:0] FetchPc,
    output logic [31:0] PcPlus4,
    output logic        Flush,
    output logic        Misalign,
    output logic [31:0] MisalignPc
);

    pc_state_t   state;
    logic [31:0] fetch_pc_q;
    logic        flush_q;
    logic [31:0] redir_pc;

`ifdef MISALIGN_TRAP_EN
    logic        redir_misaligned;
    logic        misalign_q;
    logic [31:0] misalign_pc_q;
`endif

    pc_target_align u_align (
        .redir_target  (RedirTarget),
        .redir_is_jalr (RedirIsJalr),
        .target        (redir_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned    (redir_misaligned)
`endif
    );

    // A redirect wins over a same-cycle handshake: the old PC counts as
    // accepted but its increment is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            flush_q    <= 1'b0;
        end else if (RedirValid) begin
            flush_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (redir_misaligned) begin
                state <= ST_TRAP;
            end else begin
                state      <= ST_FETCH;
                fetch_pc_q <= redir_pc;
            end
`else
            state      <= ST_FETCH;
            fetch_pc_q <= redir_pc;
`endif
        end else begin
            flush_q <= 1'b0;
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (FetchReady) fetch_pc_q <= fetch_pc_q + PC_STEP;
                default:  state <= state;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q    <= 1'b0;
            misalign_pc_q <= 32'h0;
        end else if (RedirValid) begin
            misalign_q    <= redir_misaligned;
            misalign_pc_q <= redir_misaligned ? redir_pc : 32'h0;
        end
    end

    assign Misalign   = misalign_q;
    assign MisalignPc = misalign_pc_q;
`else
    assign Misalign   = 1'b0;
    assign MisalignPc = 32'h0;
`endif

    assign FetchValid = (state == ST_FETCH);
    assign FetchPc    = fetch_pc_q;
    assign PcPlus4    = fetch_pc_q + PC_STEP;
    assign Flush      = flush_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of the fetch stream.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        RedirValid;
    logic [31:0] RedirTarget;
    logic        RedirIsJalr;
    logic        FetchReady;
    logic        FetchValid;
    logic [31:0] FetchPc;
    logic [31:0] PcPlus4;
    logic        Flush;
    logic        Misalign;
    logic [31:0] MisalignPc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] mpc;
    } exp_t;

    exp_t sb[$];

    // model state: "running" = past the post-reset idle cycle, "trapped" = waiting for aligned redirect
    logic        m_running = 1'b0;
    logic        m_trapped = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic        m_flush   = 1'b0;
    logic        m_mis     = 1'b0;
    logic [31:0] m_mpc     = 32'h0;

    pc_gen dut (
        .clk         (clk),
        .rst         (rst),
        .RedirValid  (RedirValid),
        .RedirTarget (RedirTarget),
        .RedirIsJalr (RedirIsJalr),
        .FetchReady  (FetchReady),
        .FetchValid  (FetchValid),
        .FetchPc     (FetchPc),
        .PcPlus4     (PcPlus4),
        .Flush       (Flush),
        .Misalign    (Misalign),
        .MisalignPc  (MisalignPc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    always @(posedge clk) begin
        logic [31:0] t;
        logic        running, trapped, flush, mis;
        logic [31:0] pc, mpc;
        exp_t        e;
        running = m_running; trapped = m_trapped; pc = m_pc;
        flush = m_flush; mis = m_mis; mpc = m_mpc;
        if (rst) begin
            running = 1'b0; trapped = 1'b0; pc = 32'h0;
            flush = 1'b0; mis = 1'b0; mpc = 32'h0;
        end else if (RedirValid) begin
            t = RedirTarget;
            if (RedirIsJalr) t = (t / 2) * 2;
            flush   = 1'b1;
            running = 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
                trapped = 1'b1; mis = 1'b1; mpc = t;
            end else begin
                trapped = 1'b0; mis = 1'b0; mpc = 32'h0; pc = t;
            end
`else
            pc = (t / 4) * 4;
`endif
        end else begin
            flush = 1'b0;
            if (!running) running = 1'b1;
            else if (!trapped && FetchReady) pc = pc + 32'd4;
        end
        e.valid = running && !trapped;
        e.pc    = pc;
        e.flush = flush;
        e.mis   = mis;
        e.mpc   = mpc;
        sb.push_back(e);
        m_running <= running; m_trapped <= trapped; m_pc <= pc;
        m_flush <= flush; m_mis <= mis; m_mpc <= mpc;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("FetchValid", {31'h0, FetchValid}, {31'h0, e.valid});
            chk("FetchPc", FetchPc, e.pc);
            chk("PcPlus4", PcPlus4, e.pc + 32'd4);
            chk("Flush", {31'h0, Flush}, {31'h0, e.flush});
            chk("Misalign", {31'h0, Misalign}, {31'h0, e.mis});
            chk("MisalignPc", MisalignPc, e.mpc);
        end
    end

    task automatic cyc(input logic r, input logic rv, input logic [31:0] tgt,
                       input logic jalr, input logic rdy);
        rst = r; RedirValid = rv; RedirTarget = tgt; RedirIsJalr = jalr; FetchReady = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RedirValid = 1'b0; RedirTarget = 32'h0; RedirIsJalr = 1'b0; FetchReady = 1'b1;
        // reset then sequential stream 0,4,8,C,10
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // stall at 0x10
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // JALR redirect with same-cycle handshake
        cyc(1'b0, 1'b1, 32'h0000_1001, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // wrap at top of address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // misaligned redirect, then aligned recovery
        cyc(1'b0, 1'b1, 32'h0000_2002, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_2001, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // reset collides with redirect
        cyc(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // back-to-back redirects while stalled
        cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(1, 0) == 0) tgt = tgt & ~32'h3;
            cyc(($urandom_range(63, 0) == 0),
                ($urandom_range(5, 0) == 0),
                tgt,
                ($urandom_range(1, 0) == 1),
                ($urandom_range(9, 0) < 7));
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
